// File: rtl/rob_if.sv
// Bundle between rename/execute and the reorder buffer.
// master drives allocation and completion; slave is the ROB.
interface rob_if #(
  parameter int DEPTH = 16,
  parameter int TAGW  = $clog2(DEPTH)
);
  logic            alloc_valid;
  logic            alloc_has_dest;
  logic [2:0]      alloc_dest_arch;
  logic [4:0]      alloc_dest_phys;
  logic [4:0]      alloc_prev_phys;
  logic [TAGW-1:0] alloc_tag;
  logic            rob_full;
  logic            rob_empty;
  logic            complete_valid;
  logic [TAGW-1:0] complete_tag;
  logic            commit_valid;
  logic [2:0]      commit_arch;
  logic [4:0]      commit_phys;
  logic            new_free;
  logic [4:0]      new_free_reg;

  modport master (
    output alloc_valid, alloc_has_dest, alloc_dest_arch, alloc_dest_phys,
           alloc_prev_phys, complete_valid, complete_tag,
    input  alloc_tag, rob_full, rob_empty, commit_valid, commit_arch,
           commit_phys, new_free, new_free_reg
  );

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_dest_arch, alloc_dest_phys,
           alloc_prev_phys, complete_valid, complete_tag,
    output alloc_tag, rob_full, rob_empty, commit_valid, commit_arch,
           commit_phys, new_free, new_free_reg
  );
endinterface

// File: rtl/rob.sv
// In-order retirement reorder buffer: circular entry array, one commit per
// cycle, returning the superseded physical register to the free list.
module rob #(
  parameter int DEPTH = 16,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic  clk,
  input  logic  reset,
  rob_if.slave  rif
);
  localparam logic [TAGW:0] DEPTH_CNT = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] has_dest_q, has_dest_d;
  logic [2:0]       dest_arch_q [DEPTH];
  logic [2:0]       dest_arch_d [DEPTH];
  logic [4:0]       dest_phys_q [DEPTH];
  logic [4:0]       dest_phys_d [DEPTH];
  logic [4:0]       prev_phys_q [DEPTH];
  logic [4:0]       prev_phys_d [DEPTH];

  logic [TAGW-1:0]  head_q, head_d;
  logic [TAGW-1:0]  tail_q, tail_d;
  logic [TAGW:0]    count_q, count_d;

  logic             commit_valid_q, commit_valid_d;
  logic [2:0]       commit_arch_q, commit_arch_d;
  logic [4:0]       commit_phys_q, commit_phys_d;
  logic             new_free_q, new_free_d;
  logic [4:0]       new_free_reg_q, new_free_reg_d;

  logic             full;
  logic             do_commit;
  logic             do_alloc;

  assign full = (count_q == DEPTH_CNT);

  // Next-state: commit from the head, accept completions, allocate at the tail.
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    has_dest_d     = has_dest_q;
    dest_arch_d    = dest_arch_q;
    dest_phys_d    = dest_phys_q;
    prev_phys_d    = prev_phys_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_arch_d  = commit_arch_q;
    commit_phys_d  = commit_phys_q;
    new_free_d     = 1'b0;
    new_free_reg_d = new_free_reg_q;

    do_commit = valid_q[head_q] & done_q[head_q];
    do_alloc  = rif.alloc_valid & ~full;

    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + TAGW'(1);
      commit_valid_d  = 1'b1;
      commit_arch_d   = dest_arch_q[head_q];
      commit_phys_d   = dest_phys_q[head_q];
      new_free_d      = has_dest_q[head_q];
      new_free_reg_d  = prev_phys_q[head_q];
    end else begin
      head_d = head_q;
    end

    // A done head is never re-marked, so a late completion cannot resurrect it.
    if (rif.complete_valid && valid_q[rif.complete_tag] && !done_q[rif.complete_tag]) begin
      done_d[rif.complete_tag] = 1'b1;
    end else begin
      done_d = done_d;
    end

    if (do_alloc) begin
      valid_d[tail_q]     = 1'b1;
      done_d[tail_q]      = 1'b0;
      has_dest_d[tail_q]  = rif.alloc_has_dest;
      dest_arch_d[tail_q] = rif.alloc_dest_arch;
      dest_phys_d[tail_q] = rif.alloc_dest_phys;
      prev_phys_d[tail_q] = rif.alloc_prev_phys;
      tail_d              = tail_q + TAGW'(1);
    end else begin
      tail_d = tail_q;
    end

    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + (TAGW+1)'(1);
      2'b01:   count_d = count_q - (TAGW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset discarding all in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      done_q         <= '0;
      has_dest_q     <= '0;
      dest_arch_q    <= '{default: 3'd0};
      dest_phys_q    <= '{default: 5'd0};
      prev_phys_q    <= '{default: 5'd0};
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_arch_q  <= 3'd0;
      commit_phys_q  <= 5'd0;
      new_free_q     <= 1'b0;
      new_free_reg_q <= 5'd0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      has_dest_q     <= has_dest_d;
      dest_arch_q    <= dest_arch_d;
      dest_phys_q    <= dest_phys_d;
      prev_phys_q    <= prev_phys_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_arch_q  <= commit_arch_d;
      commit_phys_q  <= commit_phys_d;
      new_free_q     <= new_free_d;
      new_free_reg_q <= new_free_reg_d;
    end
  end

  assign rif.alloc_tag    = tail_q;
  assign rif.rob_full     = full;
  assign rif.rob_empty    = (count_q == '0);
  assign rif.commit_valid = commit_valid_q;
  assign rif.commit_arch  = commit_arch_q;
  assign rif.commit_phys  = commit_phys_q;
  assign rif.new_free     = new_free_q;
  assign rif.new_free_reg = new_free_reg_q;
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-based program-order model predicts each
// retirement; a monitor compares every cycle's outputs against it.
module tb_rob;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  rob_if #(.DEPTH(DEPTH)) rif ();

  rob #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .rif   (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    bit         hd;
    logic [2:0] arch;
    logic [4:0] phys;
    logic [4:0] prev;
    bit         done;
  } ent_t;

  typedef struct {
    int         edge_n;
    bit         is_rst;
    bit         hd;
    logic [2:0] arch;
    logic [4:0] phys;
    logic [4:0] prev;
  } exp_t;

  ent_t ent[$];
  exp_t exp_q[$];
  int   m_tail;
  int   edge_cnt;
  int   vectors;
  int   miscompares;
  bit   mon_en;

  logic [2:0] last_arch;
  logic [4:0] last_phys;
  logic [4:0] last_prev;

  initial begin
    edge_cnt    = 0;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    m_tail      = 0;
    last_arch   = 3'd0;
    last_phys   = 5'd0;
    last_prev   = 5'd0;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a retirement is due and checks all outputs.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      exp_t e;
      bit   exp_cv;
      bit   exp_nf;
      while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL stale_expect: got none expected event for edge %0d", e.edge_n);
      end
      exp_cv = 1'b0;
      exp_nf = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
        e = exp_q.pop_front();
        if (e.is_rst) begin
          last_arch = 3'd0;
          last_phys = 5'd0;
          last_prev = 5'd0;
        end else begin
          exp_cv    = 1'b1;
          exp_nf    = e.hd;
          last_arch = e.arch;
          last_phys = e.phys;
          last_prev = e.prev;
        end
      end
      chk("commit_valid", 32'(rif.commit_valid), 32'(exp_cv));
      chk("new_free", 32'(rif.new_free), 32'(exp_nf));
      chk("commit_arch", 32'(rif.commit_arch), 32'(last_arch));
      chk("commit_phys", 32'(rif.commit_phys), 32'(last_phys));
      chk("new_free_reg", 32'(rif.new_free_reg), 32'(last_prev));
      chk("alloc_tag", 32'(rif.alloc_tag), 32'(m_tail));
      chk("rob_full", 32'(rif.rob_full), 32'(ent.size() == DEPTH));
      chk("rob_empty", 32'(rif.rob_empty), 32'(ent.size() == 0));
    end
  end

  // One clock of stimulus; the model advances by the same edge it predicts.
  task automatic step(input bit rst, input bit a_v, input bit hd, input logic [2:0] arch,
                      input logic [4:0] phys, input logic [4:0] prev,
                      input bit c_v, input logic [3:0] c_tag);
    exp_t e;
    bit   commit;
    bit   accept;
    @(negedge clk);
    accept = !rst && a_v && (ent.size() < DEPTH);
    if (accept && c_v && (int'(c_tag) == m_tail)) c_v = 1'b0;
    reset               = rst;
    rif.alloc_valid     = a_v;
    rif.alloc_has_dest  = hd;
    rif.alloc_dest_arch = arch;
    rif.alloc_dest_phys = phys;
    rif.alloc_prev_phys = prev;
    rif.complete_valid  = c_v;
    rif.complete_tag    = c_tag;
    e.edge_n = edge_cnt + 1;
    e.is_rst = rst;
    e.hd     = 1'b0;
    e.arch   = 3'd0;
    e.phys   = 5'd0;
    e.prev   = 5'd0;
    if (rst) begin
      ent.delete();
      m_tail = 0;
      exp_q.push_back(e);
    end else begin
      commit = (ent.size() > 0) && ent[0].done;
      if (c_v) begin
        foreach (ent[i]) if (ent[i].tag == c_tag) ent[i].done = 1'b1;
      end
      if (commit) begin
        e.hd   = ent[0].hd;
        e.arch = ent[0].arch;
        e.phys = ent[0].phys;
        e.prev = ent[0].prev;
        exp_q.push_back(e);
        void'(ent.pop_front());
      end
      if (accept) begin
        ent.push_back('{tag: 4'(m_tail), hd: hd, arch: arch, phys: phys, prev: prev, done: 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 4'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 4'd0);
  endtask

  task automatic alloc(input bit hd, input logic [2:0] arch, input logic [4:0] phys,
                       input logic [4:0] prev);
    step(1'b0, 1'b1, hd, arch, phys, prev, 1'b0, 4'd0);
  endtask

  task automatic comp(input logic [3:0] tag);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b1, tag);
  endtask

  task automatic rand_step();
    bit         c_v;
    logic [3:0] c_tag;
    c_v   = ($urandom_range(0, 3) != 0);
    c_tag = 4'($urandom);
    if (ent.size() > 0 && $urandom_range(0, 4) != 0)
      c_tag = ent[$urandom_range(0, ent.size() - 1)].tag;
    step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
         ($urandom_range(0, 3) != 0), 3'($urandom), 5'($urandom), 5'($urandom),
         c_v, c_tag);
  endtask

  initial begin
    reset               = 1'b1;
    rif.alloc_valid     = 1'b0;
    rif.alloc_has_dest  = 1'b0;
    rif.alloc_dest_arch = 3'd0;
    rif.alloc_dest_phys = 5'd0;
    rif.alloc_prev_phys = 5'd0;
    rif.complete_valid  = 1'b0;
    rif.complete_tag    = 4'd0;
    do_rst();
    mon_en = 1'b1;
    do_rst();

    // Out-of-order completion, in-order retirement; tag 2 never completes.
    alloc(1'b1, 3'd1, 5'd20, 5'd8);
    alloc(1'b1, 3'd2, 5'd21, 5'd9);
    alloc(1'b1, 3'd3, 5'd22, 5'd10);
    comp(4'd1);
    comp(4'd0);
    idle(4);

    // Fill, overfill, then commit-while-full refuses the concurrent allocation.
    do_rst();
    for (int i = 0; i < DEPTH; i++) alloc(1'b1, 3'(i), 5'(i + 1), 5'(i + 16));
    alloc(1'b1, 3'd7, 5'd31, 5'd31);
    idle(1);
    comp(4'd0);
    alloc(1'b1, 3'd5, 5'd12, 5'd13);
    alloc(1'b1, 3'd6, 5'd14, 5'd15);
    idle(2);

    // No-destination instruction retires without freeing.
    do_rst();
    alloc(1'b0, 3'd4, 5'd3, 5'd29);
    comp(4'd0);
    idle(3);

    // Randomized steady-state traffic with wraparound and occasional reset.
    do_rst();
    for (int i = 0; i < 600; i++) rand_step();
    do_rst();

    // Reset with five in-flight entries, two done but blocked behind the head.
    for (int i = 0; i < 5; i++) alloc(1'b1, 3'(i), 5'(i + 2), 5'(i + 20));
    comp(4'd1);
    comp(4'd2);
    step(1'b1, 1'b1, 1'b1, 3'd1, 5'd1, 5'd1, 1'b1, 4'd0);
    idle(6);

    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
